bcd_scan_driver: RTL
====================

// Module: bcd_scan_driver
// PURPOSE
// - Display back-end for the 3-digit BCD counter. Takes three BCD digits from the counter core and
//   time-multiplexes them onto one shared 7-segment bus with 3 digit enables.
// - Adds a per-digit dead-time (anti-ghosting), a once-per-frame snapshot (no tearing),
//   leading-zero blanking and a dash for non-BCD nibbles. Outputs drive the pads directly.
// PARAMETERS
// - PRESCALE      1000  clk cycles per digit slot (dead-time + lit time); must be > BLANK_CYCLES+1
// - BLANK_CYCLES  16    cycles per slot with every digit enable off (>=1)
// - LZ_BLANK      1     1: suppress leading zeros on hundreds/tens; 0: always show all digits
// PORTS
// - clk        in   1   system clock
// - rst_n      in   1   asynchronous active-low reset
// - en         in   1   scan enable; 0 = display dark
// - digits_i   in   12  {hundreds[11:8], tens[7:4], units[3:0]} BCD from the counter core
// - seg_out    out  7   {g,f,e,d,c,b,a}, active-high, registered
// - digit_sel  out  3   one-hot active-high digit enable, bit0=units, bit2=hundreds, registered
// - frame_tick out  1   1-cycle pulse at the end of each full 3-digit frame
// BEHAVIOUR
// - Clock/reset: one clock (clk); reset is asynchronous and active-low (rst_n). All flops reset async.
// - Reset values: seg_out=0, digit_sel=0, frame_tick=0, state=IDLE, idx=0, slot counter=0, snapshot=0.
// - FSM states: IDLE, BLANK, SHOW. Slot counter width $clog2(PRESCALE).
//   IDLE : digit_sel=0, seg_out=0. en=1 -> BLANK with idx=0, counter=0.
//   BLANK: digit_sel=0 for exactly BLANK_CYCLES cycles, then -> SHOW.
//   SHOW : digit_sel=1<<idx for PRESCALE-BLANK_CYCLES cycles. On the last SHOW cycle of idx 2,
//          assert frame_tick for 1 cycle. Then -> BLANK with idx=(idx==2)?0:idx+1.
// - Snapshot: digits_i is captured into a 12-bit register on the clk edge that enters BLANK with idx=0
//   (including IDLE->BLANK). All three digits in one frame come from the same snapshot.
// - seg_out is loaded on the first BLANK cycle of each slot and holds through that slot's SHOW.
//   Segment data is therefore stable at least 1 cycle before digit_sel rises and stays stable
//   until after it falls. digit_sel never changes in the same cycle as seg_out.
// - Decode (hex of seg_out): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
//   Nibble A-F: dash, 40.
// - Leading-zero blanking (LZ_BLANK=1): hundreds==0 -> seg_out=00 in the hundreds slot. If hundreds
//   and tens are both 0 -> seg_out=00 in the tens slot as well. Units are always shown.
//   A dash counts as non-zero. Blanked slots keep their full timing: digit_sel still pulses
//   (uniform duty), only seg_out is 00.
// - en deassert (any state, any cycle): the next edge forces IDLE. Outputs 0, idx=0, counter=0,
//   no frame_tick. Re-assert restarts from digit 0 with a fresh snapshot.
// - Mid-operation async reset: outputs go to reset values immediately, without waiting for clk.
// - At most one bit of digit_sel is ever high. In steady state the frame period is exactly 3*PRESCALE.
// STRUCTURE
// - Shared package/include seg7_pkg: segment-code constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF),
//   FSM state encodings, and digit index constants (DIG_U/DIG_T/DIG_H).
// - One sub-module: seg7_decode. Combinational, 4-bit nibble + blank flag -> 7-bit segments.
//   It is shared with any future display path.
// - The top contains the FSM, slot counter, index, snapshot register and the LZ logic.
// TESTING (PRESCALE=8, BLANK_CYCLES=2 unless noted)
// - Reset/idle: rst_n=0 then en=0 for 50 cycles -> seg_out=00, digit_sel=000, frame_tick never high.
// - Scan order/timing: en=1, digits_i=12'h123 -> frames of digit_sel 000x2, 001x6, 000x2, 010x6,
//   000x2, 100x6. seg_out=4F/5B/06 in the units/tens/hundreds slots. frame_tick every 24 cycles.
// - Snapshot: change digits_i from 123 to 456 during the tens SHOW -> the rest of that frame
//   still shows 123. The next frame shows 6/5/4 (7D/6D/66).
// - LZ blanking: digits_i=12'h007 -> units 07, tens 00, hundreds 00, all 3 digit_sel pulses present.
//   Same test with LZ_BLANK=0 -> 07/3F/3F. digits_i=12'h0A0 -> units 3F, tens 40, hundreds 00.
// - en drop: deassert en during the hundreds SHOW -> next cycle outputs 0, no frame_tick.
//   Re-assert -> 2 BLANK cycles, then digit_sel=001.
// - Async reset mid-SHOW: pulse rst_n low between clk edges -> seg_out/digit_sel go 0 before the next edge.
//   Assertion run for all tests: digit_sel never has more than one bit high.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment display definitions: segment codes, scan FSM states,
// digit indices and the 3-digit BCD payload.
package seg7_pkg;

   // Segment codes, bit order {g,f,e,d,c,b,a}, active-high
   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } scan_state_e;

   typedef logic [1:0] dig_idx_t;
   localparam dig_idx_t DIG_U = 2'd0;
   localparam dig_idx_t DIG_T = 2'd1;
   localparam dig_idx_t DIG_H = 2'd2;

   // Three BCD digits as delivered by the counter core
   typedef struct packed {
      logic [3:0] hun;
      logic [3:0] ten;
      logic [3:0] uni;
   } bcd3_t;

endpackage

// File: rtl/bcd_scan_driver_if.sv
// Display bus between the counter core (master) and the scan driver (slave).
//   en         : scan enable
//   digits_i   : three BCD digits {hun, ten, uni}
//   seg_out    : shared segment bus {g..a}
//   digit_sel  : one-hot digit enable, bit0 = units
//   frame_tick : end-of-frame pulse
interface bcd_scan_driver_if;
   logic                en;
   seg7_pkg::bcd3_t     digits_i;
   logic [6:0]          seg_out;
   logic [2:0]          digit_sel;
   logic                frame_tick;

   modport master (output en, digits_i, input seg_out, digit_sel, frame_tick);
   modport slave  (input en, digits_i, output seg_out, digit_sel, frame_tick);
endinterface

// File: rtl/seg7_decode.sv
// Combinational nibble to 7-segment decoder with blank override.
//   nibble_i : 4-bit value, 0-9 decode to digits, A-F to a dash
//   blank_i  : forces all segments off
//   seg_o_c  : segments {g..a}, active-high, combinational
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       blank_i,
   output logic [6:0] seg_o_c
);

   always_comb begin
      seg_o_c = SEG_DASH;
      if (blank_i) begin
         seg_o_c = SEG_OFF;
      end else begin
         case (nibble_i)
            4'd0:    seg_o_c = SEG_0;
            4'd1:    seg_o_c = SEG_1;
            4'd2:    seg_o_c = SEG_2;
            4'd3:    seg_o_c = SEG_3;
            4'd4:    seg_o_c = SEG_4;
            4'd5:    seg_o_c = SEG_5;
            4'd6:    seg_o_c = SEG_6;
            4'd7:    seg_o_c = SEG_7;
            4'd8:    seg_o_c = SEG_8;
            4'd9:    seg_o_c = SEG_9;
            default: seg_o_c = SEG_DASH;
         endcase
      end
   end

endmodule

// File: rtl/bcd_scan_driver.sv
// Time-multiplexes three BCD digits onto one 7-segment bus with dead-time,
// per-frame snapshot and leading-zero blanking.
//   clk, rst_n : clock, async active-low reset
//   bus.slave  : en/digits_i in; seg_out/digit_sel/frame_tick out (registered)
module bcd_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned PRESCALE     = 1000,
   parameter int unsigned BLANK_CYCLES = 16,
   parameter bit          LZ_BLANK     = 1'b1
)(
   input  logic               clk,
   input  logic               rst_n,
   bcd_scan_driver_if.slave   bus
);

   localparam int unsigned CNT_W = $clog2(PRESCALE);
   localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SLOT_LAST  = CNT_W'(PRESCALE - 1);

   scan_state_e       state_q, state_d;
   dig_idx_t          idx_q,   idx_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   bcd3_t             snap_q,  snap_d;
   logic [6:0]        seg_q,   seg_d;
   logic [2:0]        sel_q,   sel_d;
   logic              tick_q,  tick_d;

   logic [3:0]        nib_c;
   logic              blank_c;
   logic [6:0]        dec_seg_c;

   // Select the current slot's nibble and apply leading-zero suppression
   always_comb begin
      nib_c   = snap_q.uni;
      blank_c = 1'b0;
      case (idx_q)
         DIG_T: begin
            nib_c   = snap_q.ten;
            blank_c = LZ_BLANK && (snap_q.hun == 4'd0) && (snap_q.ten == 4'd0);
         end
         DIG_H: begin
            nib_c   = snap_q.hun;
            blank_c = LZ_BLANK && (snap_q.hun == 4'd0);
         end
         default: begin
            nib_c   = snap_q.uni;
            blank_c = 1'b0;
         end
      endcase
   end

   seg7_decode u_dec (
      .nibble_i (nib_c),
      .blank_i  (blank_c),
      .seg_o_c  (dec_seg_c)
   );

   // Next-state and registered-output logic. The counter runs 0..PRESCALE-1
   // across a whole slot; BLANK covers the first BLANK_CYCLES counts.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      snap_d  = snap_q;
      seg_d   = seg_q;
      sel_d   = 3'b000;
      tick_d  = 1'b0;

      if (!bus.en) begin
         state_d = ST_IDLE;
         idx_d   = DIG_U;
         cnt_d   = '0;
         seg_d   = SEG_OFF;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_BLANK;
               idx_d   = DIG_U;
               cnt_d   = '0;
               snap_d  = bus.digits_i;
            end
            ST_BLANK: begin
               cnt_d = cnt_q + CNT_W'(1);
               // Segments change one edge after digit_sel falls, so the two
               // never switch together
               if (cnt_q == '0) seg_d = dec_seg_c;
               if (cnt_q == CNT_BLANK_LAST) begin
                  state_d = ST_SHOW;
                  sel_d   = 3'b001 << idx_q;
               end
            end
            ST_SHOW: begin
               if (cnt_q == CNT_SLOT_LAST) begin
                  state_d = ST_BLANK;
                  cnt_d   = '0;
                  if (idx_q == DIG_H) begin
                     idx_d  = DIG_U;
                     snap_d = bus.digits_i;
                  end else begin
                     idx_d = idx_q + 2'd1;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
                  sel_d = 3'b001 << idx_q;
               end
            end
            default: begin
               state_d = ST_IDLE;
               idx_d   = DIG_U;
               cnt_d   = '0;
               seg_d   = SEG_OFF;
            end
         endcase
      end

      tick_d = (state_d == ST_SHOW) && (idx_d == DIG_H) && (cnt_d == CNT_SLOT_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= DIG_U;
         cnt_q   <= '0;
         snap_q  <= '0;
         seg_q   <= SEG_OFF;
         sel_q   <= 3'b000;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         snap_q  <= snap_d;
         seg_q   <= seg_d;
         sel_q   <= sel_d;
         tick_q  <= tick_d;
      end
   end

   assign bus.seg_out    = seg_q;
   assign bus.digit_sel  = sel_q;
   assign bus.frame_tick = tick_q;

endmodule
